// File: rtl/sram_reshuffle_reader_pkg.sv
// Shared parameters, FSM encoding and word-unpacking helper for the reshuffle reader.
package sram_reshuffle_reader_pkg;

  localparam int CH_NUM       = 4;
  localparam int ACT_PER_ADDR = 4;
  localparam int BW_PER_ACT   = 12;
  localparam int MAP_W        = 12;
  localparam int MAP_H        = 12;
  localparam int ADDR_W       = 6;

  localparam int WORD_W    = CH_NUM * ACT_PER_ADDR * BW_PER_ACT;
  localparam int CH_W      = ACT_PER_ADDR * BW_PER_ACT;
  localparam int PIX_TOTAL = CH_NUM * MAP_W * MAP_H;
  localparam int CHI_W     = $clog2(CH_NUM);
  localparam int ACT_W     = $clog2(ACT_PER_ADDR);
  localparam int X_W       = $clog2(MAP_W);
  localparam int Y_W       = $clog2(MAP_H);
  localparam int ENTRY_W   = BW_PER_ACT + CHI_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Channel 0 sits in the top slice of the word; act 0 (top-left) is the top of its slice.
  function automatic logic [BW_PER_ACT-1:0] pick_act(
    input logic [WORD_W-1:0] word,
    input logic [CHI_W-1:0]  c,
    input logic [ACT_W-1:0]  act
  );
    int lsb;
    lsb = (CH_NUM - 1 - int'(c)) * CH_W + (ACT_PER_ADDR - 1 - int'(act)) * BW_PER_ACT;
    return word[lsb +: BW_PER_ACT];
  endfunction

endpackage

// File: rtl/sram_reshuffle_reader_out_fifo2.sv
// Two-entry output FIFO carrying {data, ch, last}; its head drives the pixel port directly.
module out_fifo2
  import sram_reshuffle_reader_pkg::*;
#(
  parameter int W = ENTRY_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem [2];
  logic         wptr;
  logic         rptr;
  logic [1:0]   cnt;
  logic         do_push;
  logic         do_pop;

  // A pop in the same cycle frees the slot, so a full FIFO may still accept a push.
  assign do_pop  = pop && (cnt != 2'd0);
  assign do_push = push && ((cnt != 2'd2) || do_pop);

  assign rdata = mem[rptr];
  assign full  = (cnt == 2'd2);
  assign empty = (cnt == 2'd0);

  // Storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wptr   <= 1'b0;
      rptr   <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wptr] <= wdata;
        wptr      <= ~wptr;
      end
      if (do_pop) begin
        rptr <= ~rptr;
      end
      cnt <= cnt + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/sram_reshuffle_reader.sv
// Unpacks a 2x2-tiled feature map from four SRAM banks into a serial pixel stream.
//   state | meaning
//   IDLE  | waiting for start; counters cleared on start
//   RUN   | issuing one read per cycle while FIFO credit allows
//   DRAIN | all reads issued; waiting for the last pixel to handshake
module sram_reshuffle_reader
  import sram_reshuffle_reader_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_W-1:0]     sram_raddr_0,
  output logic [ADDR_W-1:0]     sram_raddr_1,
  output logic [ADDR_W-1:0]     sram_raddr_2,
  output logic [ADDR_W-1:0]     sram_raddr_3,
  input  logic [WORD_W-1:0]     sram_rdata_0,
  input  logic [WORD_W-1:0]     sram_rdata_1,
  input  logic [WORD_W-1:0]     sram_rdata_2,
  input  logic [WORD_W-1:0]     sram_rdata_3,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BW_PER_ACT-1:0] out_data,
  output logic [CHI_W-1:0]      out_ch,
  output logic                  out_last
);

  state_t              state;
  state_t              state_nxt;
  logic [CHI_W-1:0]    c_cnt;
  logic [Y_W-1:0]      y_cnt;
  logic [X_W-1:0]      x_cnt;
  logic [Y_W-1:0]      tr;
  logic [X_W-1:0]      tc;
  logic [ADDR_W-1:0]   addr_cur;
  logic [1:0]          bank_cur;
  logic [ACT_W-1:0]    act_cur;
  logic [ADDR_W-1:0]   raddr;
  logic                rd_vld;
  logic [1:0]          rd_bank;
  logic [ACT_W-1:0]    rd_act;
  logic [CHI_W-1:0]    rd_ch;
  logic                rd_last;
  logic [WORD_W-1:0]   rdata_sel;
  logic [ENTRY_W-1:0]  fifo_wdata;
  logic [ENTRY_W-1:0]  fifo_rdata;
  logic                fifo_full;
  logic                fifo_empty;
  logic [1:0]          fifo_entries;
  logic                pop;
  logic                pix_last;
  logic                credit_ok;
  logic                issue;
  logic                clear_cnt;
  logic                done_nxt;

  assign pop      = out_valid && out_ready;
  assign pix_last = (c_cnt == CHI_W'(CH_NUM - 1)) && (y_cnt == Y_W'(MAP_H - 1))
                 && (x_cnt == X_W'(MAP_W - 1));

  // Occupancy plus the read in flight must stay below two; a pop this cycle returns a slot.
  assign fifo_entries = fifo_full ? 2'd2 : (fifo_empty ? 2'd0 : 2'd1);
  assign credit_ok    = ({1'b0, fifo_entries} + {2'b0, rd_vld}) < (3'd2 + {2'b0, pop});

  // Pixel (c,y,x) to bank/address/act position.
  always_comb begin
    tr       = y_cnt >> 1;
    tc       = x_cnt >> 1;
    bank_cur = {tr[0], tc[0]};
    act_cur  = {y_cnt[0], x_cnt[0]};
    addr_cur = ADDR_W'((int'(tr) >> 1) * (MAP_W / 4) + (int'(tc) >> 1));
  end

  // Next-state and control strobes.
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    clear_cnt = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          clear_cnt = 1'b1;
        end
      end
      RUN: begin
        if (credit_ok) begin
          issue = 1'b1;
          if (pix_last) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && out_last) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register and the one-cycle done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= done_nxt;
    end
  end

  // Channel-major raster counters, advanced once per issued read.
  always_ff @(posedge clk) begin
    if (rst || clear_cnt) begin
      c_cnt <= '0;
      y_cnt <= '0;
      x_cnt <= '0;
    end else if (issue) begin
      if (x_cnt == X_W'(MAP_W - 1)) begin
        x_cnt <= '0;
        if (y_cnt == Y_W'(MAP_H - 1)) begin
          y_cnt <= '0;
          c_cnt <= c_cnt + 1'b1;
        end else begin
          y_cnt <= y_cnt + 1'b1;
        end
      end else begin
        x_cnt <= x_cnt + 1'b1;
      end
    end
  end

  // Read address plus the tag that travels with the read; reset drops any read in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      raddr   <= '0;
      rd_vld  <= 1'b0;
      rd_bank <= '0;
      rd_act  <= '0;
      rd_ch   <= '0;
      rd_last <= 1'b0;
    end else begin
      rd_vld <= issue;
      if (issue) begin
        raddr   <= addr_cur;
        rd_bank <= bank_cur;
        rd_act  <= act_cur;
        rd_ch   <= c_cnt;
        rd_last <= pix_last;
      end
    end
  end

  // Select the returning bank word.
  always_comb begin
    rdata_sel = sram_rdata_0;
    case (rd_bank)
      2'd0: rdata_sel = sram_rdata_0;
      2'd1: rdata_sel = sram_rdata_1;
      2'd2: rdata_sel = sram_rdata_2;
      2'd3: rdata_sel = sram_rdata_3;
      default: rdata_sel = sram_rdata_0;
    endcase
  end

  assign fifo_wdata = {pick_act(rdata_sel, rd_ch, rd_act), rd_ch, rd_last};

  out_fifo2 #(.W(ENTRY_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rd_vld),
    .pop   (pop),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign {out_data, out_ch, out_last} = fifo_rdata;
  assign busy = (state != IDLE);

  assign sram_raddr_0 = raddr;
  assign sram_raddr_1 = raddr;
  assign sram_raddr_2 = raddr;
  assign sram_raddr_3 = raddr;

endmodule
